pkt_store_fwd: RTL and testbench

- Store-and-forward packet buffer. Sits directly downstream of the packet driver interface and consumes its byte stream (data/sop/eop/vld).
- Accepts bytes with no backpressure on the input side, since the input has no ready. Validates framing and length, then releases only complete, well-formed packets downstream.
- Downstream uses a valid/ready handshake. Malformed, oversize and overflowing packets are discarded whole; a partial packet is never forwarded.

---
 rtl/pkt_store_fwd.sv | 213 +++++++++++++++++++++
 tb/tb_pkt_store_fwd.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_store_fwd.sv
// Store-and-forward packet buffer: commits only complete, well-formed packets, then forwards them.
// Optional statistics counters (pkt_cnt, drop_cnt) are enabled by defining PKT_SF_STAT_EN.
module pkt_store_fwd #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned MIN_LEN = 1,
    parameter int unsigned MAX_LEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_sop,
    input  logic       in_eop,
    input  logic       in_vld,
    output logic [7:0] out_data,
    output logic       out_sop,
    output logic       out_eop,
    output logic       out_vld,
    input  logic       out_rdy
`ifdef PKT_SF_STAT_EN
    ,
    output logic [15:0] pkt_cnt,
    output logic [15:0] drop_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned LW = $clog2(MAX_LEN + 1) + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [LW-1:0] MIN_L   = LW'(MIN_LEN);
    localparam logic [LW-1:0] MAX_L   = LW'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_DROP
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_spec_q, wr_spec_d;
    logic [PW-1:0] wr_cmt_q, wr_cmt_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [LW-1:0] len_q, len_d;

    logic [8:0]    mem [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [8:0]    mem_wdata;
    logic [8:0]    rd_word;

    logic [PW-1:0] wptr;
    logic [LW-1:0] new_len;
    logic          accept;
    logic          full;
    logic          too_long;
    logic [1:0]    drop_inc;
    logic          pkt_inc;

    logic [7:0]    out_data_q, out_data_d;
    logic          out_sop_q, out_sop_d;
    logic          out_eop_q, out_eop_d;
    logic          out_vld_q, out_vld_d;
    logic          first_q, first_d;

    // Input side: speculative write, commit on good eop, rewind otherwise.
    always_comb begin
        state_d   = state_q;
        wr_spec_d = wr_spec_q;
        wr_cmt_d  = wr_cmt_q;
        len_d     = len_q;
        mem_we    = 1'b0;
        mem_waddr = wr_spec_q[AW-1:0];
        mem_wdata = {in_eop, in_data};
        drop_inc  = '0;
        pkt_inc   = 1'b0;

        accept   = in_vld && (in_sop || (state_q == S_RECV));
        // A sop always restarts at the committed pointer, which implicitly rewinds any partial packet.
        wptr     = in_sop ? wr_cmt_q : wr_spec_q;
        new_len  = in_sop ? LW'(1) : len_q + LW'(1);
        full     = (wptr - rd_q) == DEPTH_P;
        too_long = new_len > MAX_L;

        if (in_vld) begin
            if (in_sop && (state_q == S_RECV)) begin
                drop_inc = 2'd1;
            end
            if (accept) begin
                if (full || too_long) begin
                    drop_inc  = drop_inc + 2'd1;
                    wr_spec_d = wr_cmt_q;
                    len_d     = '0;
                    state_d   = in_eop ? S_IDLE : S_DROP;
                end else begin
                    mem_we    = 1'b1;
                    mem_waddr = wptr[AW-1:0];
                    wr_spec_d = wptr + PW'(1);
                    len_d     = new_len;
                    if (in_eop) begin
                        state_d = S_IDLE;
                        len_d   = '0;
                        if (new_len >= MIN_L) begin
                            wr_cmt_d = wptr + PW'(1);
                            pkt_inc  = 1'b1;
                        end else begin
                            wr_spec_d = wr_cmt_q;
                            drop_inc  = drop_inc + 2'd1;
                        end
                    end else begin
                        state_d = S_RECV;
                    end
                end
            end else if (in_eop && (state_q == S_DROP)) begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_word = mem[rd_q[AW-1:0]];

    // Output side: one registered stage, refilled from the committed region whenever it empties or drains.
    always_comb begin
        rd_d       = rd_q;
        out_data_d = out_data_q;
        out_sop_d  = out_sop_q;
        out_eop_d  = out_eop_q;
        out_vld_d  = out_vld_q;
        first_d    = first_q;

        if ((rd_q != wr_cmt_q) && (!out_vld_q || out_rdy)) begin
            rd_d       = rd_q + PW'(1);
            out_data_d = rd_word[7:0];
            out_eop_d  = rd_word[8];
            out_sop_d  = first_q;
            out_vld_d  = 1'b1;
            first_d    = rd_word[8];
        end else if (out_vld_q && out_rdy) begin
            out_vld_d = 1'b0;
            out_sop_d = 1'b0;
            out_eop_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_spec_q  <= '0;
            wr_cmt_q   <= '0;
            rd_q       <= '0;
            len_q      <= '0;
            out_data_q <= '0;
            out_sop_q  <= 1'b0;
            out_eop_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            first_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_spec_q  <= wr_spec_d;
            wr_cmt_q   <= wr_cmt_d;
            rd_q       <= rd_d;
            len_q      <= len_d;
            out_data_q <= out_data_d;
            out_sop_q  <= out_sop_d;
            out_eop_q  <= out_eop_d;
            out_vld_q  <= out_vld_d;
            first_q    <= first_d;
        end
    end

    assign out_data = out_data_q;
    assign out_sop  = out_sop_q;
    assign out_eop  = out_eop_q;
    assign out_vld  = out_vld_q;

`ifdef PKT_SF_STAT_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [16:0] drop_sum;

    // An abandoned packet and a failed restart can both drop in one cycle, hence the 2-bit increment.
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_inc);
        drop_cnt_d = drop_sum[16] ? '1 : drop_sum[15:0];
        if (pkt_inc && (pkt_cnt_q != '1)) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;
`else
    logic unused_stat;
    assign unused_stat = ^{drop_inc, pkt_inc};
`endif

endmodule

// File: tb/tb_pkt_store_fwd.sv
// Self-checking bench for pkt_store_fwd: vector table plus hand sequences, scoreboard on the output side.
module tb_pkt_store_fwd;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_sop, in_eop, in_vld;
    logic       sel_s;
    logic       vld_a, vld_b;

    logic [7:0] out_data;
    logic       out_sop, out_eop, out_vld, out_rdy;
    logic [7:0] s_data;
    logic       s_sop, s_eop, s_vld, s_rdy;
`ifdef PKT_SF_STAT_EN
    logic [15:0] pkt_cnt, drop_cnt, s_pkt_cnt, s_drop_cnt;
`endif

    int unsigned rdy_mode;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [9:0]  exp_q[$];

    always #5 clk = ~clk;

    assign vld_a = in_vld & ~sel_s;
    assign vld_b = in_vld & sel_s;

    pkt_store_fwd #(.DEPTH(64), .MIN_LEN(1), .MAX_LEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_vld(vld_a),
        .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_vld(out_vld),
        .out_rdy(out_rdy)
`ifdef PKT_SF_STAT_EN
        , .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
`endif
    );

    pkt_store_fwd #(.DEPTH(16), .MIN_LEN(1), .MAX_LEN(16)) dut_s (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_vld(vld_b),
        .out_data(s_data), .out_sop(s_sop), .out_eop(s_eop), .out_vld(s_vld),
        .out_rdy(s_rdy)
`ifdef PKT_SF_STAT_EN
        , .pkt_cnt(s_pkt_cnt), .drop_cnt(s_drop_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // 0: held low, 1: held high, 2: random each cycle
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 2) out_rdy = 1'($urandom_range(0, 1));
        else out_rdy = (rdy_mode == 1);
    end

    logic       hold_pend = 1'b0;
    logic [9:0] hold_val;
    logic [9:0] got;

    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            got = {out_sop, out_eop, out_data};
            if (hold_pend) begin
                check("hold_vld", 32'(out_vld), 32'd1);
                check("hold_word", 32'(got), 32'(hold_val));
            end
            if (out_vld && out_rdy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: got %0h, expected no output", got);
                end else begin
                    check("out_word", 32'(got), 32'(exp_q.pop_front()));
                end
            end
            hold_pend = out_vld && !out_rdy;
            hold_val  = got;
        end
    end

    task automatic drive(input logic [7:0] d, input logic s, input logic e, input logic v);
        @(posedge clk);
        #1;
        in_data = d;
        in_sop  = s;
        in_eop  = e;
        in_vld  = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_pkt(input logic [7:0] base, input int n, input bit push);
        for (int i = 0; i < n; i++) begin
            drive(base + 8'(i), i == 0, i == n - 1, 1'b1);
            if (push) exp_q.push_back({1'(i == 0), 1'(i == n - 1), base + 8'(i)});
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        repeat (3) @(posedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check({name, "_idle"}, 32'(out_vld), 32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       sop, eop, vld;
        logic       keep;
        logic       exp_sop, exp_eop;
    } vec_t;

    vec_t vecs[13];
    int   s_cnt;

    initial begin
        vecs[0]  = '{8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'hA0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{8'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{8'hB0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{8'hB1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{8'h77, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{8'h66, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{8'hC0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{8'hC1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{8'hC2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; sel_s = 1'b0; rdy_mode = 1; s_rdy = 1'b0;
        in_data = '0; in_sop = 1'b0; in_eop = 1'b0; in_vld = 1'b0;
        #22;
        check("rst_vld", 32'(out_vld), 32'd0);
        check("rst_word", 32'({out_sop, out_eop, out_data}), 32'd0);
        check("rst_s_vld", 32'(s_vld), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        idle(2);

        // Single packet with eop-to-valid latency.
        send_pkt(8'h11, 4, 1'b1);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("lat_vld_c1", 32'(out_vld), 32'd0);
        @(negedge clk);
        check("lat_vld_c2", 32'(out_vld), 32'd1);
        drain("single");
`ifdef PKT_SF_STAT_EN
        check("pkt_cnt_single", 32'(pkt_cnt), 32'd1);
`endif

        // Vector table: stray bytes, missing eop, 1-byte packet, gaps.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].data, vecs[i].sop, vecs[i].eop, vecs[i].vld);
            if (vecs[i].keep) exp_q.push_back({vecs[i].exp_sop, vecs[i].exp_eop, vecs[i].data});
        end
        idle(1);
        drain("table");
`ifdef PKT_SF_STAT_EN
        check("drop_cnt_framing", 32'(drop_cnt), 32'd1);
        check("pkt_cnt_table", 32'(pkt_cnt), 32'd4);
`endif

        // Oversize packet is discarded whole; the next one passes.
        send_pkt(8'h40, 33, 1'b0);
        send_pkt(8'hE0, 4, 1'b1);
        idle(1);
        drain("oversize");
`ifdef PKT_SF_STAT_EN
        check("drop_cnt_oversize", 32'(drop_cnt), 32'd2);
`endif

        // 20 packets of 8 contiguous bytes, spaced so a 50% drain keeps up with the 64-byte buffer.
        rdy_mode = 2;
        for (int p = 0; p < 20; p++) begin
            send_pkt(8'(p * 8), 8, 1'b1);
            idle(16);
        end
        rdy_mode = 1;
        drain("random_rdy");
`ifdef PKT_SF_STAT_EN
        check("drop_cnt_random", 32'(drop_cnt), 32'd2);
        check("pkt_cnt_random", 32'(pkt_cnt), 32'd25);
`endif

        // Small buffer overflow: first 10-byte packet kept, second dropped.
        sel_s = 1'b1;
        send_pkt(8'h30, 10, 1'b0);
        send_pkt(8'h50, 10, 1'b0);
        idle(3);
        sel_s = 1'b0;
        @(negedge clk);
        check("s_pending_vld", 32'(s_vld), 32'd1);
        @(posedge clk); #1; s_rdy = 1'b1;
        s_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s_vld && s_rdy) begin
                if (s_cnt < 10)
                    check("s_word", 32'({s_sop, s_eop, s_data}),
                          32'({1'(s_cnt == 0), 1'(s_cnt == 9), 8'h30 + 8'(s_cnt)}));
                s_cnt++;
            end
        end
        check("s_byte_count", 32'(s_cnt), 32'd10);
`ifdef PKT_SF_STAT_EN
        check("s_drop_cnt", 32'(s_drop_cnt), 32'd1);
`endif

        // Reset with a committed packet pending and a partial packet in flight.
        rdy_mode = 0;
        idle(2);
        send_pkt(8'h90, 4, 1'b0);
        drive(8'hF0, 1'b1, 1'b0, 1'b1);
        drive(8'hF1, 1'b0, 1'b0, 1'b1);
        drive(8'hF2, 1'b0, 1'b0, 1'b1);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #3;
        check("pend_vld", 32'(out_vld), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_vld", 32'(out_vld), 32'd0);
        check("async_rst_word", 32'({out_sop, out_eop, out_data}), 32'd0);
        @(posedge clk); @(posedge clk); #1; rst = 1'b0;
        rdy_mode = 1;
        idle(2);
        send_pkt(8'hD0, 5, 1'b1);
        idle(1);
        drain("after_rst");
`ifdef PKT_SF_STAT_EN
        check("pkt_cnt_after_rst", 32'(pkt_cnt), 32'd1);
        check("drop_cnt_after_rst", 32'(drop_cnt), 32'd0);
`endif

        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
